mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 122 ++++++++++++
 tb/tb_mac_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a frame of unsigned 32-bit products into a saturating
// ACC_W-bit accumulator and presents the total, beat count and overflow flag
// through a valid/ready result port.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | frame empty, waiting for its first beat
// ACCUM | at least one beat of the current frame accepted
// DONE  | frame closed, result held until the consumer takes it
module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [32:1]      prod,
  input  logic             prod_last,
  input  logic             clear,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W:1]   acc_data,
  output logic [CNT_W:1]   acc_count,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W:1]   r_acc;
  logic [ACC_W:1]   w_acc_nxt;
  logic [CNT_W:1]   r_cnt;
  logic [CNT_W:1]   w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  // Low through reset and until the first clock edge after it, so the input
  // side never advertises ready while the block is still coming out of reset.
  logic             r_up;

  logic             w_accept;
  logic [ACC_W+1:1] w_sum;
  logic             w_sat;
  logic [ACC_W:1]   w_acc_inc;
  logic [CNT_W:1]   w_cnt_inc;

  assign prod_ready = r_up && (r_state != S_DONE) && !clear;
  assign w_accept   = prod_valid && prod_ready;

  // One extra bit catches the carry out of the accumulator; that carry is the
  // saturation condition.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 31){1'b0}}, prod};
  assign w_sat     = w_sum[ACC_W+1];
  assign w_acc_inc = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W:1];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  assign acc_valid = (r_state == S_DONE);
  assign acc_data  = r_acc;
  assign acc_count = r_cnt;
  assign acc_ovf   = r_ovf;

  // State register and frame datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_up    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_up    <= 1'b1;
    end
  end

  // Next-state and next-datapath values; every path starts from "hold".
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_accept) begin
          w_acc_nxt   = w_acc_inc;
          w_cnt_nxt   = w_cnt_inc;
          w_ovf_nxt   = r_ovf | w_sat;
          w_state_nxt = prod_last ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        // clear is deliberately ignored here: only the consumer retires a result.
        if (acc_ready) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (ACC_W=40 and ACC_W=34) share one
// stimulus stream; a frame-level model predicts every output each cycle and
// directed literal checks pin the model to hand-computed values.
module tb_mac_accumulator;

  localparam longint unsigned LIM40  = (64'd1 << 40) - 64'd1;
  localparam longint unsigned LIM34  = (64'd1 << 34) - 64'd1;
  localparam int              CNTMAX = 255;

  logic        clk;
  logic        rst_n;
  logic        prod_valid;
  logic [32:1] prod;
  logic        prod_last;
  logic        clear;
  logic        acc_ready;

  logic        prod_ready40, acc_valid40, acc_ovf40;
  logic [40:1] acc_data40;
  logic [8:1]  acc_count40;
  logic        prod_ready34, acc_valid34, acc_ovf34;
  logic [34:1] acc_data34;
  logic [8:1]  acc_count34;

  int n_checks = 0;
  int n_fail   = 0;

  mac_accumulator #(.ACC_W(40), .CNT_W(8)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready40),
    .prod(prod), .prod_last(prod_last), .clear(clear), .acc_valid(acc_valid40),
    .acc_ready(acc_ready), .acc_data(acc_data40), .acc_count(acc_count40),
    .acc_ovf(acc_ovf40)
  );

  mac_accumulator #(.ACC_W(34), .CNT_W(8)) u_dut34 (
    .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready34),
    .prod(prod), .prod_last(prod_last), .clear(clear), .acc_valid(acc_valid34),
    .acc_ready(acc_ready), .acc_data(acc_data34), .acc_count(acc_count34),
    .acc_ovf(acc_ovf34)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [63:0]     p64;
  longint unsigned m_acc40, m_acc34;
  bit              m_ovf40, m_ovf34;
  int              m_cnt;
  bit              m_done;
  bit              m_up;

  assign p64 = {32'd0, prod};

  function automatic longint unsigned min_u(input longint unsigned a, input longint unsigned b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_up <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      m_acc40 <= 0; m_acc34 <= 0; m_ovf40 <= 1'b0; m_ovf34 <= 1'b0;
    end else begin
      m_up <= 1'b1;
      if (m_done) begin
        if (acc_ready) begin
          m_done <= 1'b0; m_cnt <= 0;
          m_acc40 <= 0; m_acc34 <= 0; m_ovf40 <= 1'b0; m_ovf34 <= 1'b0;
        end
      end else if (clear) begin
        m_cnt <= 0;
        m_acc40 <= 0; m_acc34 <= 0; m_ovf40 <= 1'b0; m_ovf34 <= 1'b0;
      end else if (m_up && prod_valid) begin
        m_acc40 <= min_u(m_acc40 + p64, LIM40);
        m_acc34 <= min_u(m_acc34 + p64, LIM34);
        m_ovf40 <= m_ovf40 | (m_acc40 + p64 > LIM40);
        m_ovf34 <= m_ovf34 | (m_acc34 + p64 > LIM34);
        m_cnt   <= (m_cnt + 1 > CNTMAX) ? CNTMAX : m_cnt + 1;
        m_done  <= prod_last;
      end
    end
  end

  // Every cycle, away from the active edge, compare both instances to the model.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = m_up && !m_done && !clear;
    chk("cmp_ready40", prod_ready40, exp_rdy);
    chk("cmp_ready34", prod_ready34, exp_rdy);
    chk("cmp_valid40", acc_valid40, m_done);
    chk("cmp_valid34", acc_valid34, m_done);
    chk("cmp_data40",  acc_data40,  m_acc40);
    chk("cmp_data34",  acc_data34,  m_acc34);
    chk("cmp_count40", acc_count40, longint'(m_cnt));
    chk("cmp_count34", acc_count34, longint'(m_cnt));
    chk("cmp_ovf40",   acc_ovf40,   m_ovf40);
    chk("cmp_ovf34",   acc_ovf34,   m_ovf34);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [32:1] p, input logic last);
    prod_valid = 1'b1;
    prod       = p;
    prod_last  = last;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("hs_valid_low", acc_valid40, 0);
    chk("hs_count_zero", acc_count40, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; prod_valid = 1'b0; prod = '0; prod_last = 1'b0;
    clear = 1'b0; acc_ready = 1'b0;

    #3;
    chk("rst_ready", prod_ready40, 0);
    chk("rst_valid", acc_valid40, 0);
    chk("rst_data",  acc_data40, 0);
    #19;                                 // t=22, between edges
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", prod_ready40, 0);
    step();
    chk("ready_after_first_edge", prod_ready40, 1);

    // two-beat frame
    beat(32'd549760785, 1'b0);
    chk("two_valid_mid", acc_valid40, 0);
    beat(32'd240, 1'b1);
    chk("two_valid",  acc_valid40, 1);
    chk("two_data",   acc_data40, 64'd549761025);
    chk("two_count",  acc_count40, 2);
    chk("two_ovf",    acc_ovf40, 0);
    handshake();

    // saturation on the 34-bit instance
    for (int i = 0; i < 4; i++) beat(32'd4294836225, 1'b0);
    chk("sat_pre_data34", acc_data34, 64'd17179344900);
    chk("sat_pre_ovf34",  acc_ovf34, 0);
    beat(32'd4294836225, 1'b1);
    chk("sat_data34",  acc_data34, 64'd17179869183);
    chk("sat_ovf34",   acc_ovf34, 1);
    chk("sat_data40",  acc_data40, 64'd21474181125);
    chk("sat_ovf40",   acc_ovf40, 0);
    chk("sat_count",   acc_count34, 5);
    handshake();
    chk("sat_ovf_cleared", acc_ovf34, 0);

    // count saturation
    for (int i = 0; i < 299; i++) beat(32'd1, 1'b0);
    beat(32'd1, 1'b1);
    chk("cnt_data",  acc_data40, 300);
    chk("cnt_count", acc_count40, 255);
    handshake();

    // single zero beat, hold in DONE with clear and a presented beat
    beat(32'd0, 1'b1);
    chk("single_valid", acc_valid40, 1);
    chk("single_data",  acc_data40, 0);
    chk("single_count", acc_count40, 1);
    prod_valid = 1'b1; prod = 32'd7;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      step();
      chk("hold_valid", acc_valid40, 1);
      chk("hold_count", acc_count40, 1);
      chk("hold_data",  acc_data40, 0);
      chk("hold_ready", prod_ready40, 0);
    end
    clear = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("single_retire_valid", acc_valid40, 0);
    chk("single_retire_count", acc_count40, 0);
    chk("single_retire_ready", prod_ready40, 1);
    prod_valid = 1'b0;

    // clear mid-frame with a beat presented
    beat(32'd240, 1'b0);
    beat(32'd240, 1'b0);
    chk("clr_pre_data", acc_data40, 480);
    prod_valid = 1'b1; prod = 32'd99; clear = 1'b1;
    #1;
    chk("clr_ready", prod_ready40, 0);
    step();
    clear = 1'b0; prod_valid = 1'b0;
    chk("clr_data",  acc_data40, 0);
    chk("clr_count", acc_count40, 0);
    beat(32'd24, 1'b1);
    chk("clr_next_data",  acc_data40, 24);
    chk("clr_next_count", acc_count40, 1);
    handshake();

    // async reset mid-frame
    beat(32'd10, 1'b0);
    beat(32'd10, 1'b0);
    #2; rst_n = 1'b0; #1;
    chk("arst_mid_data",  acc_data40, 0);
    chk("arst_mid_count", acc_count40, 0);
    chk("arst_mid_ready", prod_ready40, 0);
    @(posedge clk); #3;
    rst_n = 1'b1; #1;
    chk("arst_mid_ready_hold", prod_ready40, 0);
    step();
    chk("arst_mid_ready_up", prod_ready40, 1);

    // async reset in DONE
    beat(32'd5, 1'b1);
    chk("arst_done_pre_valid", acc_valid40, 1);
    #2; rst_n = 1'b0; #1;
    chk("arst_done_valid", acc_valid40, 0);
    chk("arst_done_data",  acc_data40, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();
    beat(32'd10, 1'b0);
    beat(32'd10, 1'b1);
    chk("post_rst_data",  acc_data40, 20);
    chk("post_rst_count", acc_count40, 2);
    chk("post_rst_valid", acc_valid40, 1);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
